// File: rtl/pe_pkg.sv
// Shared types for the PE-select sequencer and anything that drives it.
package pe_pkg;

    typedef enum logic {PE_SEL_SINGLE, PE_SEL_SWEEP} pe_sel_mode_e;
    typedef enum logic {SEQ_IDLE, SEQ_ISSUE} pe_seq_state_e;

endpackage

// File: rtl/pe_select_sequencer_if.sv
// Command and select handshake bundle between array controller and PE select sequencer.
interface pe_select_sequencer_if
    import pe_pkg::*;
#(
    parameter int ADDR_WIDTH = 3,
    parameter int NUM_OUT    = 1 << ADDR_WIDTH,
    parameter int CNT_WIDTH  = ADDR_WIDTH + 1
);

    logic                  cmd_valid;
    logic                  cmd_ready;
    pe_sel_mode_e          cmd_mode;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [CNT_WIDTH-1:0]  cmd_len;
    logic                  sel_valid;
    logic                  sel_ready;
    logic [NUM_OUT-1:0]    sel;
    logic [ADDR_WIDTH-1:0] sel_idx;
    logic                  done;
    logic                  err;

    modport master (
        output cmd_valid, cmd_mode, cmd_addr, cmd_len, sel_ready,
        input  cmd_ready, sel_valid, sel, sel_idx, done, err
    );

    modport slave (
        input  cmd_valid, cmd_mode, cmd_addr, cmd_len, sel_ready,
        output cmd_ready, sel_valid, sel, sel_idx, done, err
    );

endinterface

// File: rtl/pe_sel_decode.sv
// Combinational index+enable to one-hot decode; all-zero when disabled or index out of range.
module pe_sel_decode #(
    parameter int ADDR_WIDTH = 3,
    parameter int NUM_OUT    = 1 << ADDR_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0] idx,
    input  logic                  en,
    output logic [NUM_OUT-1:0]    onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (en && (idx == ADDR_WIDTH'(i))) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pe_select_sequencer.sv
// Sequenced one-hot PE select: first select one cycle after command accept, one per cycle after.
// Each select holds while sel_ready is low; no new command is taken until the last select is accepted.
module pe_select_sequencer
    import pe_pkg::*;
#(
    parameter int ADDR_WIDTH = 3,
    parameter int NUM_OUT    = 1 << ADDR_WIDTH,
    parameter int CNT_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    pe_select_sequencer_if.slave  bus
);

    localparam logic [ADDR_WIDTH:0]   NUM_OUT_W = (ADDR_WIDTH + 1)'(NUM_OUT);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(NUM_OUT - 1);

    pe_seq_state_e         state_q, nxt_state;
    logic [ADDR_WIDTH-1:0] idx_q, nxt_idx;
    logic [CNT_WIDTH-1:0]  rem_q, nxt_rem;
    logic                  nxt_done, nxt_err;
    logic [NUM_OUT-1:0]    nxt_sel;

    logic                  sel_valid_q;
    logic [NUM_OUT-1:0]    sel_q;
    logic [ADDR_WIDTH-1:0] sel_idx_q;
    logic                  done_q;
    logic                  err_q;

    assign bus.cmd_ready = (state_q == SEQ_IDLE) && !rst;
    assign bus.sel_valid = sel_valid_q;
    assign bus.sel       = sel_q;
    assign bus.sel_idx   = sel_idx_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

    // Next-state is computed here so the select outputs can be registered from it directly.
    always_comb begin
        nxt_state = state_q;
        nxt_idx   = idx_q;
        nxt_rem   = rem_q;
        nxt_done  = 1'b0;
        nxt_err   = 1'b0;
        case (state_q)
            SEQ_IDLE: begin
                if (bus.cmd_valid) begin
                    if ({1'b0, bus.cmd_addr} >= NUM_OUT_W) begin
                        nxt_err = 1'b1;
                    end else if ((bus.cmd_mode == PE_SEL_SWEEP) && (bus.cmd_len == '0)) begin
                        nxt_done = 1'b1;
                    end else begin
                        nxt_idx   = bus.cmd_addr;
                        nxt_rem   = (bus.cmd_mode == PE_SEL_SINGLE) ? CNT_WIDTH'(1) : bus.cmd_len;
                        nxt_state = SEQ_ISSUE;
                    end
                end
            end
            SEQ_ISSUE: begin
                if (bus.sel_ready) begin
                    if (rem_q > CNT_WIDTH'(1)) begin
                        nxt_rem = rem_q - CNT_WIDTH'(1);
                        nxt_idx = (idx_q == LAST_IDX) ? '0 : idx_q + ADDR_WIDTH'(1);
                    end else begin
                        nxt_state = SEQ_IDLE;
                        nxt_done  = 1'b1;
                    end
                end
            end
            default: nxt_state = SEQ_IDLE;
        endcase
    end

    pe_sel_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_OUT    (NUM_OUT)
    ) u_decode (
        .idx    (nxt_idx),
        .en     (nxt_state == SEQ_ISSUE),
        .onehot (nxt_sel)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SEQ_IDLE;
            idx_q       <= '0;
            rem_q       <= '0;
            sel_valid_q <= 1'b0;
            sel_q       <= '0;
            sel_idx_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= nxt_state;
            idx_q       <= nxt_idx;
            rem_q       <= nxt_rem;
            sel_valid_q <= (nxt_state == SEQ_ISSUE);
            sel_q       <= nxt_sel;
            sel_idx_q   <= (nxt_state == SEQ_ISSUE) ? nxt_idx : '0;
            done_q      <= nxt_done;
            err_q       <= nxt_err;
        end
    end

endmodule

// File: tb/tb_pe_select_sequencer.sv
// Bench for pe_select_sequencer at NUM_OUT=6: directed scenarios then randomized commands vs a queue model.
module tb_pe_select_sequencer;
    import pe_pkg::*;

    localparam int AW = 3;
    localparam int N  = 6;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pe_select_sequencer_if #(.ADDR_WIDTH(AW), .NUM_OUT(N), .CNT_WIDTH(CW)) bus ();

    pe_select_sequencer #(.ADDR_WIDTH(AW), .NUM_OUT(N), .CNT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int   tests = 0;
    int   fails = 0;
    int   exp_q[$];
    logic exp_done = 1'b0;
    logic exp_err  = 1'b0;
    logic last_acc = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rnd_ready(input int pct);
        return $urandom_range(0, 99) < pct;
    endfunction

    // One clock: drive inputs, check cmd_ready, advance the model across the edge, check registered outputs.
    task automatic cycle(input logic v, input logic m, input logic [AW-1:0] a,
                         input logic [CW-1:0] l, input logic r, input logic rs);
        logic busy;
        int   n;
        int   hd;
        rst           = rs;
        bus.cmd_valid = v;
        bus.cmd_mode  = pe_sel_mode_e'(m);
        bus.cmd_addr  = a;
        bus.cmd_len   = l;
        bus.sel_ready = r;
        #1;
        busy = (exp_q.size() > 0);
        chk("cmd_ready", {31'b0, bus.cmd_ready}, {31'b0, !busy && !rs});
        last_acc = v && !busy && !rs;
        @(posedge clk);
        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (rs) begin
            exp_q.delete();
        end else if (busy) begin
            if (r) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) exp_done = 1'b1;
            end
        end else if (v) begin
            if (int'(a) >= N) begin
                exp_err = 1'b1;
            end else begin
                n = m ? int'(l) : 1;
                if (n == 0) exp_done = 1'b1;
                for (int k = 0; k < n; k++) exp_q.push_back((int'(a) + k) % N);
            end
        end
        #1;
        hd = (exp_q.size() > 0) ? exp_q[0] : 0;
        chk("sel_valid", {31'b0, bus.sel_valid}, {31'b0, exp_q.size() > 0});
        chk("sel_idx", {29'b0, bus.sel_idx}, hd);
        chk("sel", {26'b0, bus.sel}, (exp_q.size() > 0) ? (32'd1 << hd) : 32'd0);
        chk("done", {31'b0, bus.done}, {31'b0, exp_done});
        chk("err", {31'b0, bus.err}, {31'b0, exp_err});
        chk("sel_onehot0", {31'b0, $onehot0(bus.sel)}, 32'd1);
    endtask

    task automatic send(input logic m, input logic [AW-1:0] a, input logic [CW-1:0] l, input int pct);
        int n = 0;
        do begin
            cycle(1'b1, m, a, l, rnd_ready(pct), 1'b0);
            n++;
        end while (!last_acc && n < 300);
        tests++;
        assert (last_acc) else begin
            fails++;
            $error("FAIL accept_timeout observed=%0d expected=1", last_acc);
        end
    endtask

    task automatic drain(input int pct, input logic allow_rst);
        int n = 0;
        while (exp_q.size() > 0 && n < 300) begin
            cycle(1'b0, 1'b0, '0, '0, rnd_ready(pct), allow_rst && ($urandom_range(0, 59) == 0));
            n++;
        end
        tests++;
        assert (exp_q.size() == 0) else begin
            fails++;
            $error("FAIL drain_timeout observed=%0d expected=0", exp_q.size());
        end
    endtask

    initial begin
        int wrap_exp[4];
        wrap_exp = '{4, 5, 0, 1};
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_mode  = PE_SEL_SINGLE;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.sel_ready = 1'b0;

        // Reset state
        cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
        chk("rst_sel", {26'b0, bus.sel}, 32'd0);
        cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);

        // SINGLE addr 5
        send(1'b0, 3'd5, 4'd9, 100);
        chk("single_sel", {26'b0, bus.sel}, 32'b10_0000);
        chk("single_idx", {29'b0, bus.sel_idx}, 32'd5);
        cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        chk("single_done", {31'b0, bus.done}, 32'd1);
        chk("single_clear", {26'b0, bus.sel}, 32'd0);

        // SWEEP wrap around the top of a 6-PE array
        send(1'b1, 3'd4, 4'd4, 100);
        chk("wrap_idx0", {29'b0, bus.sel_idx}, wrap_exp[0]);
        for (int k = 1; k < 4; k++) begin
            cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
            chk("wrap_idx", {29'b0, bus.sel_idx}, wrap_exp[k]);
        end
        cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        chk("wrap_done", {31'b0, bus.done}, 32'd1);

        // Back-pressure on the second select
        send(1'b1, 3'd0, 4'd3, 100);
        cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
            chk("bp_hold", {29'b0, bus.sel_idx}, 32'd1);
        end
        cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        chk("bp_idx2", {29'b0, bus.sel_idx}, 32'd2);
        cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        chk("bp_done", {31'b0, bus.done}, 32'd1);

        // Out-of-range address and zero-length sweep
        send(1'b0, 3'd6, 4'd1, 100);
        chk("range_err", {31'b0, bus.err}, 32'd1);
        send(1'b1, 3'd7, 4'd5, 100);
        chk("range_err_sweep", {26'b0, bus.sel}, 32'd0);
        send(1'b1, 3'd2, 4'd0, 100);
        chk("zero_len_done", {31'b0, bus.done}, 32'd1);
        chk("zero_len_nosel", {31'b0, bus.sel_valid}, 32'd0);

        // Sweep longer than the array revisits PEs
        send(1'b1, 3'd3, 4'd15, 70);
        drain(70, 1'b0);

        // Reset mid-sweep, then a normal SINGLE
        send(1'b1, 3'd0, 4'd8, 100);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
        chk("midrst_done", {31'b0, bus.done}, 32'd0);
        chk("midrst_valid", {31'b0, bus.sel_valid}, 32'd0);
        cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        send(1'b0, 3'd2, 4'd0, 100);
        chk("post_rst_idx", {29'b0, bus.sel_idx}, 32'd2);
        drain(100, 1'b0);

        // Randomized commands, ready patterns and occasional resets
        for (int c = 0; c < 250; c++) begin
            logic           m;
            logic [AW-1:0]  a;
            logic [CW-1:0]  l;
            int             pct;
            m   = 1'($urandom_range(0, 1));
            a   = AW'($urandom_range(0, 7));
            l   = ($urandom_range(0, 5) == 0) ? '0 : CW'($urandom_range(1, 15));
            pct = $urandom_range(30, 100);
            send(m, a, l, pct);
            drain(pct, 1'b1);
            if ($urandom_range(0, 3) == 0) cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pe_select_sequencer.md
# pe_select_sequencer

Registered, parameterised PE-select generator: accepts a command over a valid/ready handshake and drives a one-hot select vector, either for a single PE or sweeping a run of consecutive PEs with wrap-around. Each select is held until the downstream consumer accepts it. Sits between the array controller and the PE array, replacing a bare combinational address decode wherever selects must be sequenced, back-pressured or range-checked.

## Interface
- ADDR_WIDTH, 3: width of PE index.
- NUM_OUT, 1<<ADDR_WIDTH: number of select lines.
  - Legal range is 2..2^ADDR_WIDTH.
  - Need not be a power of two.
- CNT_WIDTH, ADDR_WIDTH+1: width of sweep length.

Reset is synchronous, active-high; one clock domain.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_mode  in  1  0 = SINGLE, 1 = SWEEP.
- cmd_addr  in  ADDR_WIDTH  start PE index.
- cmd_len  in  CNT_WIDTH  number of selects in SWEEP; ignored in SINGLE.
- sel_valid  out  1  select vector valid.
- sel_ready  in  1  downstream accepts the current select.
- sel  out  NUM_OUT  one-hot select; all-zero when sel_valid=0.
- sel_idx  out  ADDR_WIDTH  binary index of the asserted bit; 0 when idle.
- done  out  1  one-cycle pulse after the last select of a command is accepted.
- err  out  1  one-cycle pulse when a command is rejected for out-of-range address.

## Operation
- States: IDLE, ISSUE.
- cmd_ready = (state==IDLE) && !rst.
- IDLE, on accepted command:
  - If cmd_addr >= NUM_OUT: err=1 next cycle, no select issued, stay IDLE.
  - If SWEEP and cmd_len==0: done=1 next cycle, no select issued, stay IDLE.
  - Otherwise: idx<=cmd_addr; remaining<=(SINGLE ? 1 : cmd_len); go to ISSUE.
- ISSUE:
  - Outputs: sel_valid=1, sel=1<<idx, sel_idx=idx.
  - On sel_ready=0: sel and sel_idx hold stable.
  - On sel_ready=1 with remaining>1: remaining-=1; idx<=(idx==NUM_OUT-1) ? 0 : idx+1 (wrap-around).
  - On sel_ready=1 with remaining==1: go to IDLE, done=1 next cycle.
- cmd_len > NUM_OUT is legal: the sweep wraps and revisits PEs; exactly cmd_len selects are issued.
- Commands presented while in ISSUE are not accepted (cmd_ready=0) and must be held by the source.
- sel is never multi-hot; it is all-zero whenever sel_valid=0.

## Timing
- Reset values:
  - State IDLE.
  - sel_valid=0, sel='0, sel_idx=0, done=0, err=0.
  - cmd_ready=0 while rst=1.
- Reset asserted mid-sweep:
  - Command abandoned next edge, no done pulse.
  - Outputs return to reset values in the cycle after the rst edge.
- Latency: command accepted at edge N -> first sel_valid=1 in cycle N+1.
- Throughput: one select per cycle while sel_ready=1.
- Last handshake at edge M:
  - Cycle M+1 has done=1, sel_valid=0, cmd_ready=1.
  - Next command may be accepted at edge M+1; its first select appears in cycle M+2.
- err and done are registered single-cycle pulses, never asserted together.
- All outputs except cmd_ready are registered.

## Structure
- Shared package pe_pkg holds:
  - typedef enum logic {PE_SEL_SINGLE, PE_SEL_SWEEP} pe_sel_mode_e.
  - typedef enum logic {SEQ_IDLE, SEQ_ISSUE} pe_seq_state_e.
- One sub-module, pe_sel_decode: combinational index+enable to one-hot of NUM_OUT lines.
  - Driven by idx and (state==ISSUE).
  - Its output is registered into sel.
- idx/remaining counters and the FSM live in the top.

## Test plan
- SINGLE: NUM_OUT=8, addr=5, sel_ready=1 -> cycle after accept sel=8'b0010_0000, sel_idx=5; next cycle done=1, sel=0.
- SWEEP wrap: addr=6, len=4, sel_ready=1 -> sel_idx sequence 6,7,0,1 on consecutive cycles, then done pulse.
- Back-pressure: SWEEP addr=0, len=3, sel_ready low for 3 cycles on the second select -> sel_idx=1 held stable for those cycles; no skip or repeat; done after idx 2 is accepted.
- Range/zero-length: NUM_OUT=6, addr=6 -> err pulse, sel stays 0. SWEEP len=0 -> done pulse only, sel_valid never asserted.
- Reset mid-sweep: SWEEP addr=0, len=8, rst asserted after 3 accepts -> next cycle all outputs at reset values, no done pulse. A SINGLE command after rst drops behaves normally.
